// File: rtl/tt_hostport_pkg.sv
// ============================================================================
//  Module      : tt_hostport_pkg
//  Description : Shared state encoding and uio bit map for the host port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_hostport_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE   = 1'b0;
    localparam state_t ACKING = 1'b1;

    localparam int REQ_BIT   = 0;
    localparam int RW_BIT    = 1;
    localparam int ACK_BIT   = 2;
    localparam int FULL_BIT  = 3;
    localparam int EMPTY_BIT = 4;
    localparam int ERR_BIT   = 5;
    localparam int STAT_BIT  = 6;

    localparam logic [7:0] UIO_OE_MASK = 8'h3C;

    function automatic logic [7:0] status_byte(input logic err, input logic full,
                                               input logic empty, input logic [3:0] cnt);
        return {err, full, empty, 1'b0, cnt};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_host_port_responder_if.sv
// ============================================================================
//  Module      : tt_host_port_responder_if
//  Description : TT pin bundle between the host driver and the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tt_host_port_responder_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ui_in, output uio_in,
                    input  uo_out, input uio_out, input uio_oe);
    modport slave  (input  ui_in, input uio_in,
                    output uo_out, output uio_out, output uio_oe);
endinterface

`default_nettype wire

// File: rtl/tt_hostport_fifo.sv
// ============================================================================
//  Module      : tt_hostport_fifo
//  Description : DEPTH x 8 circular FIFO with registered full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_hostport_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          push_ok, pop_ok;

    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop  && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flags follow the settled count, one edge behind the push/pop.
        full_d  = (count_q == CW'(DEPTH));
        empty_d = (count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/tt_host_port_responder.sv
// ============================================================================
//  Module      : tt_host_port_responder
//  Description : Four-phase REQ/ACK host responder over a byte FIFO.
//                Optional status read enabled by TT_HOSTPORT_STATUS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_host_port_responder
    import tt_hostport_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    tt_host_port_responder_if.slave   hp
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d, vld_q, vld_d;
    logic          req_s, req_p_q, req_p_d, start;
    state_t        state_q, state_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic [7:0]    uo_q, uo_d;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          full_now, empty_now, is_read;
    logic          status_rd;
    logic [7:0]    status_val;
    logic          unused_bits;

    tt_hostport_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (hp.ui_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef TT_HOSTPORT_STATUS_EN
    logic [7:0] count_ext;
    assign count_ext   = 8'(fifo_count);
    assign status_rd   = hp.uio_in[STAT_BIT];
    assign status_val  = status_byte(err_q, fifo_full, fifo_empty, count_ext[3:0]);
    assign unused_bits = ^{hp.uio_in[7], hp.uio_in[5:2], count_ext[7:4]};
`else
    assign status_rd   = 1'b0;
    assign status_val  = 8'h00;
    assign unused_bits = ^{hp.uio_in[7:2]};
`endif

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign full_now  = (fifo_count == CW'(DEPTH));
    assign empty_now = (fifo_count == '0);
    assign is_read   = hp.uio_in[RW_BIT];
    assign start     = (state_q == IDLE) && ena && req_s && !req_p_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], hp.uio_in[REQ_BIT]};
        vld_d     = {vld_q[SYNC_STAGES-2:0], 1'b1};
        // Until the synchronizer has refilled after reset, treat REQ as already
        // high so a level held across reset cannot look like a fresh edge.
        req_p_d   = vld_q[SYNC_STAGES-1] ? req_s : 1'b1;
        state_d   = state_q;
        ack_d     = ack_q;
        err_d     = err_q;
        uo_d      = uo_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACKING;
                    ack_d   = 1'b1;
                    if (is_read) begin
                        if (status_rd) begin
                            uo_d = status_val;
                        end else if (empty_now) begin
                            err_d = 1'b1;
                        end else begin
                            fifo_pop = 1'b1;
                            uo_d     = fifo_rdata;
                        end
                    end else if (full_now) begin
                        err_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end
            ACKING: begin
                if (!req_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            req_p_q <= 1'b1;
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            uo_q    <= 8'h00;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            req_p_q <= req_p_d;
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            uo_q    <= uo_d;
        end
    end

    always_comb begin
        hp.uio_out            = 8'h00;
        hp.uio_out[ACK_BIT]   = ack_q;
        hp.uio_out[FULL_BIT]  = fifo_full;
        hp.uio_out[EMPTY_BIT] = fifo_empty;
        hp.uio_out[ERR_BIT]   = err_q;
    end

    assign hp.uo_out = uo_q;
    assign hp.uio_oe = UIO_OE_MASK;

endmodule

`default_nettype wire

// File: tb/tb_tt_host_port_responder.sv
// ============================================================================
//  Module      : tb_tt_host_port_responder
//  Description : Directed scoreboard bench for tt_host_port_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_host_port_responder;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;

    tt_host_port_responder_if hp ();

    tt_host_port_responder #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .hp    (hp)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    logic [7:0] m_uo  = 8'h00;
    logic       m_err = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_uio();
        logic [7:0] v;
        v    = 8'h00;
        v[5] = m_err;
        v[4] = (sb.size() == 0);
        v[3] = (sb.size() == DEPTH);
        return v;
    endfunction

    task automatic txn(input logic rw, input logic [7:0] d, input logic stat, input string tag);
        int up;
        int dn;
        logic [7:0] st;
        @(negedge clk);
        hp.ui_in     = d;
        hp.uio_in    = 8'h00;
        hp.uio_in[1] = rw;
        hp.uio_in[6] = stat;
        hp.uio_in[0] = 1'b1;
        up = 0;
        do begin
            @(posedge clk); #1; up++;
        end while (!hp.uio_out[2] && up < 20);
        check({tag, " ack_rise_lat"}, 8'(up), 8'd3);
        st = {m_err, (sb.size() == DEPTH), (sb.size() == 0), 1'b0, 4'(sb.size())};
        if (!rw) begin
            if (sb.size() == DEPTH) m_err = 1'b1;
            else sb.push_back(d);
        end else begin
`ifdef TT_HOSTPORT_STATUS_EN
            if (stat) m_uo = st;
            else
`endif
            if (sb.size() == 0) m_err = 1'b1;
            else m_uo = sb.pop_front();
        end
        check({tag, " uo_out"}, hp.uo_out, m_uo);
        @(negedge clk);
        hp.uio_in[0] = 1'b0;
        dn = 0;
        do begin
            @(posedge clk); #1; dn++;
        end while (hp.uio_out[2] && dn < 20);
        check({tag, " ack_fall_lat"}, 8'(dn), 8'd3);
        repeat (2) @(posedge clk);
        #1;
        check({tag, " uio_out"}, hp.uio_out, exp_uio());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_err = 1'b0;
        m_uo  = 8'h00;
    endtask

    initial begin
        int seen;
        hp.ui_in  = 8'h00;
        hp.uio_in = 8'h00;

        // Reset state
        repeat (10) @(posedge clk);
        #1;
        check("reset uo_out", hp.uo_out, 8'h00);
        check("reset uio_out", hp.uio_out, 8'h10);
        check("reset uio_oe", hp.uio_oe, 8'h3C);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single write/read
        txn(1'b0, 8'hA5, 1'b0, "wr_a5");
        txn(1'b1, 8'h00, 1'b0, "rd_a5");

        // Fill, overflow, drain
        for (int i = 1; i <= DEPTH; i++) txn(1'b0, 8'(i), 1'b0, "fill");
        txn(1'b0, 8'h55, 1'b0, "wr_full");
        for (int i = 0; i < DEPTH; i++) txn(1'b1, 8'h00, 1'b0, "drain");

        // Underflow keeps last data, ERR sticks
        do_reset();
        txn(1'b0, 8'h3C, 1'b0, "wr_3c");
        txn(1'b1, 8'h00, 1'b0, "rd_3c");
        txn(1'b1, 8'h00, 1'b0, "rd_empty");
        txn(1'b0, 8'h11, 1'b0, "wr_11_err");
        txn(1'b1, 8'h00, 1'b0, "rd_11_err");

        // ena low blocks a start; the missed edge is not replayed
        @(negedge clk);
        ena       = 1'b0;
        hp.ui_in  = 8'hEE;
        hp.uio_in = 8'h01;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (hp.uio_out[2]) seen++; end
        @(negedge clk);
        ena = 1'b1;
        repeat (5) begin @(posedge clk); #1; if (hp.uio_out[2]) seen++; end
        check("ena_low no_ack", 8'(seen), 8'd0);
        @(negedge clk);
        hp.uio_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("ena_low uio_out", hp.uio_out, exp_uio());

        // Reset mid-handshake with REQ held high
        @(negedge clk);
        hp.ui_in  = 8'h77;
        hp.uio_in = 8'h01;
        seen = 0;
        while (!hp.uio_out[2] && seen < 20) begin @(posedge clk); #1; seen++; end
        check("mid ack_high", 8'(hp.uio_out[2]), 8'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid ack_after_rst", 8'(hp.uio_out[2]), 8'd0);
        sb.delete();
        m_err = 1'b0;
        m_uo  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (hp.uio_out[2]) seen++; end
        check("mid req_held no_ack", 8'(seen), 8'd0);
        check("mid uio_out", hp.uio_out, 8'h10);
        check("mid uo_out", hp.uo_out, 8'h00);
        @(negedge clk);
        hp.uio_in = 8'h00;
        repeat (4) @(posedge clk);
        txn(1'b0, 8'h99, 1'b0, "post_wr");
        txn(1'b1, 8'h00, 1'b0, "post_rd");

        // Status read (or plain pop when the feature is absent)
        do_reset();
        txn(1'b0, 8'h21, 1'b0, "st_w1");
        txn(1'b0, 8'h22, 1'b0, "st_w2");
        txn(1'b0, 8'h23, 1'b0, "st_w3");
        txn(1'b1, 8'h00, 1'b1, "st_rd1");
        txn(1'b1, 8'h00, 1'b1, "st_rd2");
        for (int i = 0; i < DEPTH; i++) txn(1'b0, 8'h40 + 8'(i), 1'b0, "st_fill");
        txn(1'b1, 8'h00, 1'b1, "st_rd_full");
        for (int i = 0; i < DEPTH; i++) txn(1'b1, 8'h00, 1'b0, "st_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tt_host_port_responder.md
Name: tt_host_port_responder

Overview:
- Design-side responder for the parallel host handshake that the cocotb bench drives onto the TT pins (ui_in, uio_in).
- The host writes bytes into an internal FIFO and reads them back through uo_out using a four-phase REQ/ACK handshake.
- Sits directly under the tt_um top and owns uo_out, uio_out and uio_oe.

Parameters:
- DEPTH, 8, FIFO entries; power of two in 2..16.
- SYNC_STAGES, 2, synchronizer flops on REQ; minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- ena  in  1  design selected; when low, no new transaction starts
- ui_in  in  8  write data from host
- uio_in  in  8  [0]=REQ, [1]=RW (1=read, 0=write), [6]=STAT (feature only); other bits ignored
- uo_out  out  8  registered read data
- uio_out  out  8  [2]=ACK, [3]=FULL, [4]=EMPTY, [5]=ERR; other bits 0
- uio_oe  out  8  constant 8'h3C

Behaviour:
- Reset (rst_n low at a clk edge): uo_out=0, ACK=0, ERR=0, FIFO emptied (EMPTY=1, FULL=0), state=IDLE, synchronizer flops cleared.
- REQ passes through SYNC_STAGES flops to give req_s. req_p holds req_s delayed by one cycle.
- A start event is req_s=1 and req_p=0, i.e. a rising edge only. REQ held high through or after reset is ignored until it returns low and rises again.
- IDLE: on a start event with ena=1, execute the command and go to ACKING. ACK register goes high on the same edge.
  - RW=1 (read): pop the FIFO head into uo_out.
  - RW=0 (write): push ui_in, sampled on that same edge.
- ACKING: ACK=1. When req_s=0, ACK goes 0 on that edge and the state returns to IDLE.
- ena falling during ACKING does not abort the handshake.
- Latency with SYNC_STAGES=2: REQ first sampled high at edge k; command executes and ACK rises at edge k+2. ACK falls 2 edges after REQ is first sampled low.
- The host must hold ui_in and RW stable from REQ rise until ACK rises.
- Write while FULL: FIFO unchanged, ERR set, handshake completes normally.
- Read while EMPTY: uo_out unchanged, ERR set, handshake completes normally.
- ERR is sticky; only reset clears it.
- FIFO is circular with pointer wrap at DEPTH. Count width is clog2(DEPTH)+1.
- FULL = (count==DEPTH), EMPTY = (count==0); both registered, so they update on the edge after the push or pop.
- At most one push or pop per handshake, so simultaneous push and pop cannot occur.
- Reset mid-handshake: ACK drops on the reset edge and FIFO contents are lost. The host must deassert REQ before the next transaction is recognised.

Optional Feature:
- Macro: TT_HOSTPORT_STATUS_EN.
- Defined: a read with uio_in[6]=1 does not pop. It loads uo_out = {ERR, FULL, EMPTY, 1'b0, count[3:0]} (count zero-extended) and never sets ERR.
- Undefined: uio_in[6] is ignored and every read pops.

Decomposition:
- Package tt_hostport_pkg holds:
  - state enum {IDLE, ACKING};
  - uio bit-index constants REQ_BIT, RW_BIT, ACK_BIT, FULL_BIT, EMPTY_BIT, ERR_BIT, STAT_BIT;
  - UIO_OE_MASK = 8'h3C.
- Sub-module tt_hostport_fifo (DEPTH x 8; push, pop, rdata, full, empty, count; synchronous active-low reset).
- Handshake FSM and synchronizer stay in the parent.

Test Plan:
- Reset: hold rst_n low 10 cycles -> uo_out=0x00, uio_out=0x10 (EMPTY only), uio_oe=0x3C.
- Single write 0xA5 then read -> ACK rises exactly 3 clk edges after REQ is driven high. Read ACK -> uo_out=0xA5, EMPTY=1, ERR=0.
- Write 0x01..0x08 -> FULL=1 after the 8th. Write 0x55 -> ACK still returned, ERR=1. Eight reads return 0x01..0x08 in order, then EMPTY=1.
- Read on empty after writing/reading 0x3C -> uo_out stays 0x3C, ERR=1. ERR remains 1 across later valid transactions until reset.
- Reset with REQ and ACK high -> ACK=0 after the edge and FIFO empty. REQ kept high 20 cycles gives no ACK. REQ low then high gives a normal transaction.
- With TT_HOSTPORT_STATUS_EN, after 3 writes, read with STAT=1 -> uo_out=0x03 and count stays 3. With FULL and ERR set -> uo_out=0xC8 (DEPTH=8).
